// File: rtl/logic_unit_seq_pkg.sv
// Shared opcode definitions for the sequential logic unit.
// State encodings are kept private to logic_unit_seq.
package logic_unit_seq_pkg;

   localparam int ALU_LOP_W = 4;

   typedef enum logic [ALU_LOP_W-1:0] {
      ALU_LOP_AND    = 4'd0,
      ALU_LOP_OR     = 4'd1,
      ALU_LOP_XOR    = 4'd2,
      ALU_LOP_NOT    = 4'd3,
      ALU_LOP_NAND   = 4'd4,
      ALU_LOP_NOR    = 4'd5,
      ALU_LOP_XNOR   = 4'd6,
      ALU_LOP_ANDN   = 4'd7,
      ALU_LOP_POPCNT = 4'd8
   } alu_lop_e;

endpackage

// File: rtl/logic_unit_seq_popcnt_chunk.sv
// Combinational population count of one W-bit chunk.
module popcnt_chunk #(
   parameter int W = 8
) (
   input  logic [W-1:0]           data_i,
   output logic [$clog2(W+1)-1:0] count_o
);

   localparam int CW = $clog2(W+1);

   // NOTE: blocking assignments in always_comb let the running sum chain within one evaluation.
   always_comb begin
      count_o = '0;
      for (int i = 0; i < W; i++) begin
         count_o = count_o + CW'(data_i[i]);
      end
   end

endmodule

// File: rtl/logic_unit_seq.sv
// Handshaked bitwise logic unit with a multi-cycle chunked POPCNT.
// A single output register slot holds the result until the consumer takes it.
module logic_unit_seq
   import logic_unit_seq_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int CNT_CHUNK = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ALU_LOP_W-1:0] op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     y,
   output logic                 zero,
   output logic                 parity,
   output logic                 err,
   output logic                 busy
);

   localparam int N  = WIDTH / CNT_CHUNK;
   localparam int AW = $clog2(WIDTH + 1);
   localparam int CW = $clog2(CNT_CHUNK + 1);
   localparam int NW = $clog2(N + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_HOLD
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             zero_q, zero_d;
   logic             parity_q, parity_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [NW-1:0]    cnt_q, cnt_d;

   logic [CW-1:0]    chunk_cnt;
   logic [AW-1:0]    acc_sum;
   logic [WIDTH-1:0] pop_res;
   logic [WIDTH-1:0] op_res;
   logic             op_err;
   logic             accept;

   popcnt_chunk #(.W(CNT_CHUNK)) u_popcnt_chunk (
      .data_i  (shreg_q[CNT_CHUNK-1:0]),
      .count_o (chunk_cnt)
   );

   assign acc_sum = acc_q + AW'(chunk_cnt);
   assign pop_res = WIDTH'(acc_sum);

   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == S_HOLD);
   assign busy      = (state_q == S_CALC);
   assign y         = y_q;
   assign zero      = zero_q;
   assign parity    = parity_q;
   assign err       = err_q;

   // Illegal opcodes yield y=0 with err set; POPCNT never uses this path.
   always_comb begin
      op_res = '0;
      op_err = 1'b0;
      case (op)
         ALU_LOP_AND:    op_res = a & b;
         ALU_LOP_OR:     op_res = a | b;
         ALU_LOP_XOR:    op_res = a ^ b;
         ALU_LOP_NOT:    op_res = ~a;
         ALU_LOP_NAND:   op_res = ~(a & b);
         ALU_LOP_NOR:    op_res = ~(a | b);
         ALU_LOP_XNOR:   op_res = ~(a ^ b);
         ALU_LOP_ANDN:   op_res = a & ~b;
         ALU_LOP_POPCNT: op_res = '0;
         default:        op_err = 1'b1;
      endcase
   end

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      y_d      = y_q;
      zero_d   = zero_q;
      parity_d = parity_q;
      err_d    = err_q;
      shreg_d  = shreg_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;

      case (state_q)
         S_CALC: begin
            shreg_d = shreg_q >> CNT_CHUNK;
            acc_d   = acc_sum;
            cnt_d   = cnt_q - NW'(1);
            if (cnt_q == NW'(1)) begin
               y_d      = pop_res;
               zero_d   = (pop_res == '0);
               parity_d = ^pop_res;
               err_d    = 1'b0;
               state_d  = S_HOLD;
            end
         end
         default: begin
            if (state_q == S_HOLD && out_ready) begin
               state_d = S_IDLE;
            end
            // A HOLD retire and a new accept share the same edge.
            if (accept) begin
               if (op == ALU_LOP_POPCNT) begin
                  shreg_d = a;
                  acc_d   = '0;
                  cnt_d   = NW'(N);
                  state_d = S_CALC;
               end else begin
                  y_d      = op_res;
                  zero_d   = (op_res == '0);
                  parity_d = ^op_res;
                  err_d    = op_err;
                  state_d  = S_HOLD;
               end
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         y_q      <= '0;
         zero_q   <= 1'b0;
         parity_q <= 1'b0;
         err_q    <= 1'b0;
         shreg_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         y_q      <= y_d;
         zero_q   <= zero_d;
         parity_q <= parity_d;
         err_q    <= err_d;
         shreg_q  <= shreg_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed and randomised bench for logic_unit_seq (32/8 and 16/4 configurations).
module tb_logic_unit_seq;

   localparam logic [3:0] OP_AND    = 4'd0;
   localparam logic [3:0] OP_OR     = 4'd1;
   localparam logic [3:0] OP_XOR    = 4'd2;
   localparam logic [3:0] OP_NOT    = 4'd3;
   localparam logic [3:0] OP_NAND   = 4'd4;
   localparam logic [3:0] OP_POPCNT = 4'd8;

   localparam logic [31:0] VA = 32'hA5A5F00F;
   localparam logic [31:0] VB = 32'h0F0F0F0F;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  op;
   logic [31:0] a, b, y;
   logic        zero, parity, err, busy;

   logic        in_valid16, in_ready16, out_valid16, out_ready16;
   logic [3:0]  op16;
   logic [15:0] a16, b16, y16;
   logic        zero16, parity16, err16, busy16;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [15:0] y;
      logic        err;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   logic_unit_seq #(.WIDTH(32), .CNT_CHUNK(8)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .zero      (zero),
      .parity    (parity),
      .err       (err),
      .busy      (busy)
   );

   logic_unit_seq #(.WIDTH(16), .CNT_CHUNK(4)) u_dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid16),
      .in_ready  (in_ready16),
      .op        (op16),
      .a         (a16),
      .b         (b16),
      .out_valid (out_valid16),
      .out_ready (out_ready16),
      .y         (y16),
      .zero      (zero16),
      .parity    (parity16),
      .err       (err16),
      .busy      (busy16)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] z);
      exp_t r;
      int   n;
      r.y   = '0;
      r.err = 1'b0;
      case (o)
         4'd0: r.y = x & z;
         4'd1: r.y = x | z;
         4'd2: r.y = x ^ z;
         4'd3: r.y = ~x;
         4'd4: r.y = ~(x & z);
         4'd5: r.y = ~(x | z);
         4'd6: r.y = ~(x ^ z);
         4'd7: r.y = x & ~z;
         4'd8: begin
            n = 0;
            for (int i = 0; i < 16; i++) n += int'(x[i]);
            r.y = 16'(n);
         end
         default: r.err = 1'b1;
      endcase
      return r;
   endfunction

   task automatic retire16();
      exp_t e;
      if (exp_q.size() == 0) begin
         check("r16_spurious", {31'd0, out_valid16}, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("r16_y", {16'd0, y16}, {16'd0, e.y});
         check("r16_err", {31'd0, err16}, {31'd0, e.err});
         check("r16_zero", {31'd0, zero16}, {31'd0, (e.y == 16'd0)});
         check("r16_parity", {31'd0, parity16}, {31'd0, ^e.y});
      end
   endtask

   initial begin
      logic        hold_prev;
      logic [15:0] y_prev;

      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
      in_valid16 = 1'b0; out_ready16 = 1'b1; op16 = '0; a16 = '0; b16 = '0;
      tick();
      tick();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_y", y, 32'd0);
      check("rst_flags", {29'd0, zero, parity, err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      tick();

      // 1: back-to-back bitwise ops at full throughput
      in_valid = 1'b1; a = VA; b = VB; op = OP_AND;
      #1;
      check("t1_in_ready_idle", {31'd0, in_ready}, 32'd1);
      tick();
      check("t1_and_y", y, 32'h0505000F);
      check("t1_and_valid", {31'd0, out_valid}, 32'd1);
      check("t1_and_flags", {29'd0, zero, parity, err}, 32'd0);
      op = OP_OR;
      #1;
      check("t1_in_ready_hold", {31'd0, in_ready}, 32'd1);
      tick();
      check("t1_or_y", y, 32'hAFAFFF0F);
      check("t1_or_valid", {31'd0, out_valid}, 32'd1);
      op = OP_XOR;
      tick();
      check("t1_xor_y", y, 32'hAAAAFF00);
      check("t1_xor_valid", {31'd0, out_valid}, 32'd1);
      op = OP_NOT;
      tick();
      check("t1_not_y", y, 32'h5A5A0FF0);
      check("t1_not_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      tick();
      check("t1_idle_valid", {31'd0, out_valid}, 32'd0);

      // 2: POPCNT latency and busy window
      in_valid = 1'b1; op = OP_POPCNT; a = VA;
      tick();
      in_valid = 1'b0;
      #1;
      check("t2_busy_c1", {31'd0, busy}, 32'd1);
      check("t2_in_ready_c1", {31'd0, in_ready}, 32'd0);
      check("t2_valid_c1", {31'd0, out_valid}, 32'd0);
      for (int i = 2; i <= 4; i++) begin
         tick();
         check($sformatf("t2_busy_c%0d", i), {31'd0, busy}, 32'd1);
         check($sformatf("t2_in_ready_c%0d", i), {31'd0, in_ready}, 32'd0);
         check($sformatf("t2_valid_c%0d", i), {31'd0, out_valid}, 32'd0);
      end
      tick();
      check("t2_valid_c5", {31'd0, out_valid}, 32'd1);
      check("t2_busy_c5", {31'd0, busy}, 32'd0);
      check("t2_y", y, 32'h00000010);
      check("t2_flags", {29'd0, zero, parity, err}, 32'b010);
      tick();
      check("t2_idle_valid", {31'd0, out_valid}, 32'd0);

      // 3: zero result, illegal opcode, err cleared by next legal op
      in_valid = 1'b1; op = OP_XOR; a = VA; b = VA;
      tick();
      check("t3_xaa_y", y, 32'd0);
      check("t3_xaa_flags", {29'd0, zero, parity, err}, 32'b100);
      op = 4'hC;
      tick();
      check("t3_ill_y", y, 32'd0);
      check("t3_ill_flags", {29'd0, zero, parity, err}, 32'b101);
      check("t3_ill_valid", {31'd0, out_valid}, 32'd1);
      op = OP_AND; b = VB;
      tick();
      check("t3_clr_y", y, 32'h0505000F);
      check("t3_clr_err", {31'd0, err}, 32'd0);
      in_valid = 1'b0;
      tick();

      // 4: backpressure with a held follow-on op
      in_valid = 1'b1; op = OP_NAND; a = VA; b = VB; out_ready = 1'b0;
      tick();
      op = OP_XOR;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("t4_y_hold%0d", i), y, 32'hFAFAFFF0);
         check($sformatf("t4_valid_hold%0d", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("t4_in_ready_hold%0d", i), {31'd0, in_ready}, 32'd0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("t4_y_release", y, 32'hFAFAFFF0);
      check("t4_in_ready_release", {31'd0, in_ready}, 32'd1);
      tick();
      check("t4_next_y", y, 32'hAAAAFF00);
      check("t4_next_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      tick();
      check("t4_idle_valid", {31'd0, out_valid}, 32'd0);

      // 5: reset during POPCNT discards it
      in_valid = 1'b1; op = OP_POPCNT; a = VA;
      tick();
      in_valid = 1'b0;
      tick();
      check("t5_busy_c2", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      tick();
      check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
      check("t5_rst_y", y, 32'd0);
      check("t5_rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      in_valid = 1'b1; op = OP_NOT; a = VA;
      tick();
      check("t5_not_y", y, 32'h5A5A0FF0);
      check("t5_not_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("t5_no_ghost%0d", i), {31'd0, out_valid}, 32'd0);
      end

      // 6: random stream on the 16/4 instance against a reference queue
      hold_prev = 1'b0;
      y_prev    = '0;
      for (int i = 0; i < 400; i++) begin
         in_valid16  = ($urandom_range(0, 3) != 0);
         op16        = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
         a16         = 16'($urandom);
         b16         = 16'($urandom);
         out_ready16 = ($urandom_range(0, 2) != 0);
         #1;
         if (hold_prev) begin
            check("r16_stall_valid", {31'd0, out_valid16}, 32'd1);
            check("r16_stall_y", {16'd0, y16}, {16'd0, y_prev});
         end
         if (in_valid16 && in_ready16) exp_q.push_back(model16(op16, a16, b16));
         if (out_valid16 && out_ready16) retire16();
         hold_prev = out_valid16 && !out_ready16;
         y_prev    = y16;
         tick();
      end
      in_valid16  = 1'b0;
      out_ready16 = 1'b1;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (out_valid16) retire16();
         tick();
      end
      check("r16_drained", exp_q.size(), 32'd0);
      check("r16_final_valid", {31'd0, out_valid16}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
